// File: rtl/one_unit_ser_out.sv
// ---------------------------------------------------------------------------
// one_unit_ser_out
//
// Output-side reader for the one-unit FastICA matrix stages. A capture strobe
// snapshots NMAT parallel 4x4 matrices of signed Q13 elements into a register
// buffer. The 64 elements are then streamed one per valid/ready handshake, in
// row-major or column-major order within each matrix. A capture request that
// arrives while a stream is in progress is ignored and raises a sticky flag.
//
// Ports:
//   clk_ser     block clock, rising edge
//   rst_n_ser   asynchronous active-low reset
//   en_ser      capture strobe
//   col_major   traversal order latched at capture (0 row-major, 1 column-major)
//   mat_in      packed matrices, element (m,r,c) at [(m*16+(r-1)*4+(c-1))*W +: W]
//   busy        a snapshot is being streamed
//   dout        current element, bit-exact copy of the captured value
//   dout_valid  dout holds a valid element
//   dout_ready  downstream accept
//   mat_idx     matrix index of dout
//   row_idx     0-based row of dout
//   col_idx     0-based column of dout
//   last        dout is the 64th element of the snapshot
//   overrun     sticky capture-while-busy flag
//   clr_ovr     synchronous clear of overrun
// ---------------------------------------------------------------------------
module one_unit_ser_out #(
  parameter int W    = 26,
  parameter int NMAT = 4
) (
  input  logic                   clk_ser,
  input  logic                   rst_n_ser,
  input  logic                   en_ser,
  input  logic                   col_major,
  input  logic [NMAT*16*W-1:0]   mat_in,
  output logic                   busy,
  output logic [W-1:0]           dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [1:0]             mat_idx,
  output logic [1:0]             row_idx,
  output logic [1:0]             col_idx,
  output logic                   last,
  output logic                   overrun,
  input  logic                   clr_ovr
);

  localparam int NELEM = NMAT * 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e         state_q,   state_d;
  logic [5:0]     cnt_q,     cnt_d;
  logic           order_q,   order_d;
  logic           overrun_q, overrun_d;
  logic [W-1:0]   buf_q [NELEM];
  logic [W-1:0]   buf_d [NELEM];

  logic           sending;
  logic           handshake;
  logic           end_beat;
  logic           capture;
  logic           ovr_set;
  logic [5:0]     sel;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    order_d   = order_q;
    buf_d     = buf_q;

    sending   = (state_q == SEND);
    handshake = sending & dout_ready;
    end_beat  = handshake & (cnt_q == 6'd63);

    // A strobe coinciding with the final handshake recaptures without a
    // bubble; any other strobe during a stream is an overrun.
    capture   = en_ser & (~sending | end_beat);
    ovr_set   = en_ser & sending & ~capture;

    if (capture) begin
      for (int i = 0; i < NELEM; i++) begin
        buf_d[i] = mat_in[i*W +: W];
      end
      order_d = col_major;
      cnt_d   = 6'd0;
      state_d = SEND;
    end else if (handshake) begin
      cnt_d = cnt_q + 6'd1;
      if (end_beat) begin
        state_d = IDLE;
      end
    end

    // Set wins over clear when both happen in the same cycle.
    overrun_d = ovr_set | (overrun_q & ~clr_ovr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  // NOTE: the snapshot buffer is reset as well, so dout reads zero during and
  // right after reset instead of stale data.
  always_ff @(posedge clk_ser or negedge rst_n_ser) begin
    if (!rst_n_ser) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      order_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NELEM; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      order_q   <= order_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
    end
  end

  // Output decode uses registered state only. Column-major swaps the row and
  // column fields of the buffer address; the matrix field is shared.
  always_comb begin
    sel        = order_q ? {cnt_q[5:4], cnt_q[1:0], cnt_q[3:2]} : cnt_q;
    dout       = buf_q[sel];
    mat_idx    = cnt_q[5:4];
    row_idx    = order_q ? cnt_q[1:0] : cnt_q[3:2];
    col_idx    = order_q ? cnt_q[3:2] : cnt_q[1:0];
    busy       = (state_q == SEND);
    dout_valid = (state_q == SEND);
    last       = (state_q == SEND) & (cnt_q == 6'd63);
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_one_unit_ser_out.sv
// ---------------------------------------------------------------------------
// tb_one_unit_ser_out
//
// Directed bench for one_unit_ser_out: reset state, row-major and
// column-major streams with stalls, sign preservation, overrun handling,
// back-to-back capture and asynchronous reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_one_unit_ser_out;

  localparam int W    = 26;
  localparam int NMAT = 4;
  localparam int DW   = NMAT * 16 * W;

  logic          clk_ser    = 1'b0;
  logic          rst_n_ser  = 1'b1;
  logic          en_ser     = 1'b0;
  logic          col_major  = 1'b0;
  logic [DW-1:0] mat_in     = '0;
  logic          dout_ready = 1'b0;
  logic          clr_ovr    = 1'b0;
  logic          busy;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [1:0]    mat_idx;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic          last;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  one_unit_ser_out #(.W(W), .NMAT(NMAT)) dut (
    .clk_ser    (clk_ser),
    .rst_n_ser  (rst_n_ser),
    .en_ser     (en_ser),
    .col_major  (col_major),
    .mat_in     (mat_in),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .mat_idx    (mat_idx),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .last       (last),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  always #5 clk_ser = ~clk_ser;

  typedef struct {
    logic         en;
    logic         clr;
    logic         rdy;
    logic         use_b;
    logic         exp_valid;
    logic         exp_ovr;
    logic [W-1:0] exp_dout;
    logic [1:0]   exp_row;
    logic [1:0]   exp_col;
  } vec_t;

  vec_t tbl [8];

  logic [DW-1:0] data_a, data_b, data_c, data_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_ser);
    #1;
  endtask

  // Element (m,r,c), 0-based r/c, holds m*256 + (r+1)*16 + (c+1).
  function automatic logic [DW-1:0] mk_a();
    logic [DW-1:0] d;
    d = '0;
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          d[(m*16 + r*4 + c)*W +: W] = W'(m*256 + (r+1)*16 + (c+1));
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_fill(input logic [W-1:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < 64; i++) d[i*W +: W] = v;
    return d;
  endfunction

  function automatic logic [W-1:0] exp_val(input int m, input int r, input int c);
    return W'(m*256 + (r+1)*16 + (c+1));
  endfunction

  task automatic chk_beat(input string tag, input int k, input logic [W-1:0] exp,
                          input int m, input int r, input int c);
    check($sformatf("%s[%0d].valid", tag, k), {31'd0, dout_valid}, 32'd1);
    check($sformatf("%s[%0d].busy",  tag, k), {31'd0, busy},       32'd1);
    check($sformatf("%s[%0d].dout",  tag, k), {6'd0, dout},        {6'd0, exp});
    check($sformatf("%s[%0d].mat",   tag, k), {30'd0, mat_idx},    32'(m));
    check($sformatf("%s[%0d].row",   tag, k), {30'd0, row_idx},    32'(r));
    check($sformatf("%s[%0d].col",   tag, k), {30'd0, col_idx},    32'(c));
    check($sformatf("%s[%0d].last",  tag, k), {31'd0, last},       32'(k == 63));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".valid"}, {31'd0, dout_valid}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy},       32'd0);
    check({tag, ".last"},  {31'd0, last},       32'd0);
  endtask

  // Present a capture strobe for one edge; returns with beat 0 visible.
  task automatic start(input logic col, input logic [DW-1:0] d);
    mat_in    = d;
    col_major = col;
    en_ser    = 1'b1;
    check("start.valid_before", {31'd0, dout_valid}, 32'd0);
    step();
    en_ser = 1'b0;
  endtask

  initial begin
    int k, j;
    logic [3:0] pat;

    data_a = mk_a();
    data_b = mk_fill(26'h2AAAAAA);
    data_d = mk_fill(26'h1555555);
    data_c = '0;
    data_c[0*W  +: W] = 26'h0002000;
    data_c[43*W +: W] = 26'h3FFE000;

    //                en clr rdy b  vld ovr dout       row col
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h000, 2'd0, 2'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 26'h011, 2'd0, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 26'h012, 2'd0, 2'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 26'h013, 2'd0, 2'd2};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 26'h013, 2'd0, 2'd2};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 26'h014, 2'd0, 2'd3};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 26'h014, 2'd0, 2'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 26'h021, 2'd1, 2'd0};

    // ---- reset state ----
    #1 rst_n_ser = 1'b0;
    #2;
    chk_idle("rst");
    check("rst.dout",    {6'd0, dout},       32'd0);
    check("rst.overrun", {31'd0, overrun},   32'd0);
    check("rst.mat",     {30'd0, mat_idx},   32'd0);
    check("rst.row",     {30'd0, row_idx},   32'd0);
    check("rst.col",     {30'd0, col_idx},   32'd0);
    step();
    step();
    #2 rst_n_ser = 1'b1;
    step();
    chk_idle("post_rst");

    // ---- basic row-major stream ----
    dout_ready = 1'b1;
    start(1'b0, data_a);
    for (int b = 0; b < 64; b++) begin
      chk_beat("row", b, exp_val(b >> 4, (b >> 2) & 3, b & 3), b >> 4, (b >> 2) & 3, b & 3);
      step();
    end
    chk_idle("row.end");

    // ---- column-major with ready pattern 1,0,0,1 ----
    pat = 4'b1001;
    dout_ready = pat[0];
    start(1'b1, data_a);
    k = 0;
    j = 0;
    while (k < 64 && j < 400) begin
      dout_ready = pat[j % 4];
      chk_beat("colm", k, exp_val(k >> 4, k & 3, (k >> 2) & 3), k >> 4, k & 3, (k >> 2) & 3);
      step();
      if (dout_ready) k++;
      j++;
    end
    check("colm.handshakes", 32'(k), 32'd64);
    chk_idle("colm.end");

    // ---- overrun: table of single-cycle vectors ----
    col_major = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en_ser     = tbl[i].en;
      clr_ovr    = tbl[i].clr;
      dout_ready = tbl[i].rdy;
      mat_in     = tbl[i].use_b ? data_b : data_a;
      check($sformatf("tbl[%0d].valid", i), {31'd0, dout_valid}, {31'd0, tbl[i].exp_valid});
      check($sformatf("tbl[%0d].ovr", i),   {31'd0, overrun},    {31'd0, tbl[i].exp_ovr});
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl[%0d].dout", i), {6'd0, dout},     {6'd0, tbl[i].exp_dout});
        check($sformatf("tbl[%0d].row", i),  {30'd0, row_idx}, {30'd0, tbl[i].exp_row});
        check($sformatf("tbl[%0d].col", i),  {30'd0, col_idx}, {30'd0, tbl[i].exp_col});
      end
      step();
    end
    en_ser  = 1'b0;
    clr_ovr = 1'b0;
    // Remaining beats still carry the original snapshot.
    dout_ready = 1'b1;
    for (int b = 5; b < 64; b++) begin
      en_ser = (b == 20);
      chk_beat("ovr", b, exp_val(b >> 4, (b >> 2) & 3, b & 3), b >> 4, (b >> 2) & 3, b & 3);
      step();
      en_ser = 1'b0;
    end
    chk_idle("ovr.end");
    check("ovr.after_done", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr.cleared", {31'd0, overrun}, 32'd0);

    // ---- sign preservation ----
    start(1'b0, data_c);
    for (int b = 0; b < 64; b++) begin
      chk_beat("sign", b, (b == 0) ? 26'h0002000 : (b == 43) ? 26'h3FFE000 : 26'h0,
               b >> 4, (b >> 2) & 3, b & 3);
      step();
    end
    chk_idle("sign.end");

    // ---- back-to-back capture on the final handshake ----
    start(1'b0, data_a);
    for (int b = 0; b < 64; b++) begin
      if (b == 63) begin
        en_ser = 1'b1;
        mat_in = data_d;
      end
      chk_beat("b2b_a", b, exp_val(b >> 4, (b >> 2) & 3, b & 3), b >> 4, (b >> 2) & 3, b & 3);
      step();
      en_ser = 1'b0;
    end
    check("b2b.ovr", {31'd0, overrun}, 32'd0);
    for (int b = 0; b < 64; b++) begin
      chk_beat("b2b_d", b, 26'h1555555, b >> 4, (b >> 2) & 3, b & 3);
      step();
    end
    chk_idle("b2b.end");
    check("b2b.ovr_end", {31'd0, overrun}, 32'd0);

    // ---- asynchronous reset mid-stream ----
    start(1'b0, data_a);
    for (int b = 0; b < 30; b++) step();
    chk_beat("mid", 30, exp_val(1, 3, 2), 1, 3, 2);
    #2 rst_n_ser = 1'b0;
    #1;
    chk_idle("mid.rst");
    check("mid.rst.dout", {6'd0, dout},     32'd0);
    check("mid.rst.row",  {30'd0, row_idx}, 32'd0);
    step();
    step();
    #2 rst_n_ser = 1'b1;
    step();
    chk_idle("mid.released");
    start(1'b0, data_a);
    for (int b = 0; b < 64; b++) begin
      chk_beat("restart", b, exp_val(b >> 4, (b >> 2) & 3, b & 3), b >> 4, (b >> 2) & 3, b & 3);
      step();
    end
    chk_idle("restart.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
